uart_rx_packet_deframer: RTL
============================

Name: uart_rx_packet_deframer

Overview:
Sits directly downstream of the 8N1 UART receiver. It consumes the receiver's byte plus single-cycle data-ready strobe, hunts for framed packets (SYNC, LEN, payload, checksum), and buffers the payload internally. A payload is released to the system over a valid/ready byte stream with a last flag only after its checksum verifies. Framing, length, checksum, timeout and overrun errors are reported as single-cycle strobes.

Parameters:
SYSCLK_F, 24000000, system clock frequency in Hz.
BAUDRATE, 500000, UART line rate; used only for the timeout.
BYTE_W, 8, byte width. Only 8 is supported.
SYNC_BYTE, 8'hA5, frame start marker.
MAX_LEN, 16, maximum payload length in bytes. Also the buffer depth.
TIMEOUT_BYTES, 4, inter-byte timeout in byte times. TIMEOUT_CYC = TIMEOUT_BYTES*10*(SYSCLK_F/BAUDRATE), which is 1920 at the defaults.

Ports:
sys_clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  synchronous reset, active-low.
en  in  1  when low, rx_strobe is ignored.
rx_data  in  BYTE_W  byte from the UART receiver.
rx_strobe  in  1  single-cycle strobe marking rx_data valid.
out_data  out  BYTE_W  payload byte.
out_valid  out  1  out_data is valid.
out_ready  in  1  consumer accepts the byte; a transfer occurs when out_valid and out_ready are both high.
out_last  out  1  high with the final payload byte.
pkt_len  out  $clog2(MAX_LEN+1)  length of the packet being drained; valid while out_valid is high.
busy  out  1  high in any state other than HUNT.
len_err  out  1  1-cycle pulse: length field is 0 or greater than MAX_LEN.
csum_err  out  1  1-cycle pulse: checksum mismatch.
timeout_err  out  1  1-cycle pulse: inter-byte timeout.
overrun_err  out  1  1-cycle pulse: a byte arrived during DRAIN and was dropped.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to HUNT.
  - All outputs go to 0: out_data, out_valid, out_last, pkt_len, busy and every error strobe.
  - Buffer contents are don't-care.
  - Reset during DRAIN discards the packet; out_valid is 0 from the following cycle.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CSUM.
  - The checksum is valid when (LEN + sum of payload + CSUM) mod 256 == 0.
  - SYNC_BYTE is excluded from the sum. All arithmetic is 8-bit, wrap-around.
- "Strobe" below means rx_strobe && en.
- HUNT:
  - A strobe with rx_data == SYNC_BYTE moves to LEN.
  - All other bytes are silently dropped.
- LEN, on a strobe:
  - If rx_data == 0 or rx_data > MAX_LEN: len_err pulses in the next cycle and the state returns to HUNT.
  - Otherwise: latch the length, sum = rx_data, write index = 0, and move to PAYLOAD.
  - A SYNC_BYTE value arriving here is treated as a length, not as a resync.
- PAYLOAD, on a strobe:
  - Write rx_data to buf[idx], sum += rx_data, idx++.
  - After the LEN-th byte, move to CSUM.
- CSUM, on a strobe:
  - If (sum + rx_data) mod 256 == 0: move to DRAIN.
  - Otherwise: csum_err pulses in the next cycle and the state returns to HUNT.
- DRAIN:
  - out_valid = 1 from the cycle after the CSUM strobe.
  - out_data = buf[rd_idx], with rd_idx starting at 0.
  - out_last = 1 when rd_idx == LEN-1.
  - On each transfer rd_idx increments.
  - out_data, out_last and pkt_len hold stable while out_valid && !out_ready.
  - After the last transfer, out_valid = 0 and the state returns to HUNT in the next cycle.
  - Any strobe during DRAIN is dropped and overrun_err pulses; a dropped SYNC_BYTE is not remembered.
- Timeout:
  - In LEN, PAYLOAD and CSUM, a cycle counter clears on each strobe and on state entry.
  - When the counter reaches TIMEOUT_CYC: timeout_err pulses and the state returns to HUNT.
  - There is no timeout in HUNT or DRAIN.
- en low:
  - Strobes are ignored in every state and the timeout keeps running.
  - en low during DRAIN does not stop the drain.
- All error strobes are registered, last exactly one cycle, and are mutually exclusive.
- Back-to-back packets: a SYNC strobe arriving in the same cycle as the last transfer counts as an overrun, because the state is still DRAIN.

Test Plan:
1. Good packet:
   - Stimulus: strobe A5 03 11 22 33 97, with out_ready held at 1.
   - Response: out_data 11, 22, 33 on consecutive cycles; out_last only with 33; pkt_len = 3; no error strobes.
2. Checksum error:
   - Stimulus: A5 03 11 22 33 98.
   - Response: one csum_err pulse; out_valid never rises; busy = 0 afterwards.
3. Resync after garbage:
   - Stimulus: 00 FF A5 01 7E 81.
   - Response: a single output byte 7E with out_last = 1 and pkt_len = 1.
4. Length errors:
   - Stimulus: A5 11 (17 > MAX_LEN), then A5 00, then a valid packet A5 01 05 FA.
   - Response: two len_err pulses, then the byte 05 is delivered.
5. Timeout:
   - Stimulus: A5 02 10, then no strobes.
   - Response: timeout_err pulses exactly 1920 cycles after the 10 strobe, and the state is HUNT.
   - Follow-up: a subsequent good packet is accepted.
6. Backpressure, overrun and reset:
   - Stimulus: during the drain of packet 1, hold out_ready at 0 for 10 cycles.
   - Response: out_data is held for all 10 cycles.
   - Stimulus: inject a strobe during DRAIN.
   - Response: one overrun_err pulse; the payload is unchanged.
   - Stimulus: assert rst_n = 0 mid-drain.
   - Response: out_valid = 0 on the next cycle.

Source files
------------

// File: rtl/uart_rx_packet_deframer.sv
// Packet deframer that sits behind an 8N1 UART receiver.
// It hunts for frames of the form SYNC, LEN, LEN payload bytes, CSUM.
// The payload is buffered, and it is released on a valid/ready stream
// only after the checksum has verified.
//
// Ports:
//   sys_clk_i      system clock, rising edge
//   rst_n_i        synchronous reset, active low
//   en_i           gates rx_strobe_i
//   rx_data_i      received byte
//   rx_strobe_i    single-cycle strobe, rx_data_i valid
//   out_data_o     payload byte        out_valid_o  payload byte valid
//   out_ready_i    consumer ready      out_last_o   final payload byte
//   pkt_len_o      length of packet being drained
//   busy_o         not hunting
//   len_err_o, csum_err_o, timeout_err_o, overrun_err_o   1-cycle error strobes
//
// state   | meaning
// HUNT    | waiting for SYNC_BYTE
// LEN     | expecting the length byte
// PAYLOAD | storing payload bytes into the buffer
// CSUM    | expecting the checksum byte
// DRAIN   | presenting the verified payload downstream
module uart_rx_packet_deframer #(
  parameter int          SYSCLK_F      = 24000000,
  parameter int          BAUDRATE      = 500000,
  parameter int          BYTE_W        = 8,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int          MAX_LEN       = 16,
  parameter int          TIMEOUT_BYTES = 4
) (
  input  logic                             sys_clk_i,
  input  logic                             rst_n_i,
  input  logic                             en_i,
  input  logic [BYTE_W-1:0]                rx_data_i,
  input  logic                             rx_strobe_i,
  output logic [BYTE_W-1:0]                out_data_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             out_last_o,
  output logic [$clog2(MAX_LEN+1)-1:0]     pkt_len_o,
  output logic                             busy_o,
  output logic                             len_err_o,
  output logic                             csum_err_o,
  output logic                             timeout_err_o,
  output logic                             overrun_err_o
);

  localparam int LW          = $clog2(MAX_LEN+1);
  localparam int AW          = $clog2(MAX_LEN);
  localparam int TIMEOUT_CYC = TIMEOUT_BYTES * 10 * (SYSCLK_F / BAUDRATE);
  localparam int TW          = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]     TMR_LOAD  = TW'(TIMEOUT_CYC - 1);
  localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       idx_q, idx_d;
  logic [LW-1:0]       rd_q, rd_d;
  logic [BYTE_W-1:0]   sum_q, sum_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                len_err_q, len_err_d;
  logic                csum_err_q, csum_err_d;
  logic                tmo_err_q, tmo_err_d;
  logic                ovr_err_q, ovr_err_d;
  logic                wr_en;
  logic [BYTE_W-1:0]   mem [MAX_LEN];

  logic                strobe;
  logic                timed;
  logic                expired;
  logic                xfer;
  logic [BYTE_W-1:0]   csum_sum;

  assign strobe   = rx_strobe_i && en_i;
  assign timed    = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);
  // A strobe in the same cycle as the terminal count wins over the timeout.
  assign expired  = timed && !strobe && (tmr_q == '0);
  assign xfer     = out_valid_o && out_ready_i;
  assign csum_sum = sum_q + rx_data_i;

  assign out_valid_o   = (state_q == DRAIN);
  assign out_data_o    = out_valid_o ? mem[rd_q[AW-1:0]] : '0;
  assign out_last_o    = out_valid_o && (rd_q == len_q - 1'b1);
  assign pkt_len_o     = out_valid_o ? len_q : '0;
  assign busy_o        = (state_q != HUNT);
  assign len_err_o     = len_err_q;
  assign csum_err_o    = csum_err_q;
  assign timeout_err_o = tmo_err_q;
  assign overrun_err_o = ovr_err_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    rd_d       = rd_q;
    sum_d      = sum_q;
    len_err_d  = 1'b0;
    csum_err_d = 1'b0;
    tmo_err_d  = 1'b0;
    ovr_err_d  = 1'b0;
    wr_en      = 1'b0;

    // Outside the timed states the timer is held at its load value, so
    // entering LEN starts a fresh count; every strobe restarts it too.
    if (strobe || !timed) begin
      tmr_d = TMR_LOAD;
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - 1'b1;
    end else begin
      tmr_d = tmr_q;
    end

    case (state_q)
      HUNT: begin
        if (strobe && (rx_data_i == SYNC_BYTE)) state_d = LEN;
      end
      LEN: begin
        if (strobe) begin
          if ((rx_data_i == '0) || (rx_data_i > MAX_LEN_B)) begin
            len_err_d = 1'b1;
            state_d   = HUNT;
          end else begin
            len_d   = rx_data_i[LW-1:0];
            sum_d   = rx_data_i;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end else if (expired) begin
          tmo_err_d = 1'b1;
          state_d   = HUNT;
        end
      end
      PAYLOAD: begin
        if (strobe) begin
          wr_en = 1'b1;
          sum_d = sum_q + rx_data_i;
          idx_d = idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) state_d = CSUM;
        end else if (expired) begin
          tmo_err_d = 1'b1;
          state_d   = HUNT;
        end
      end
      CSUM: begin
        if (strobe) begin
          if (csum_sum == '0) begin
            rd_d    = '0;
            state_d = DRAIN;
          end else begin
            csum_err_d = 1'b1;
            state_d    = HUNT;
          end
        end else if (expired) begin
          tmo_err_d = 1'b1;
          state_d   = HUNT;
        end
      end
      DRAIN: begin
        if (strobe) ovr_err_d = 1'b1;
        if (xfer) begin
          if (out_last_o) state_d = HUNT;
          else            rd_d    = rd_q + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      state_q    <= HUNT;
      len_q      <= '0;
      idx_q      <= '0;
      rd_q       <= '0;
      sum_q      <= '0;
      tmr_q      <= TMR_LOAD;
      len_err_q  <= 1'b0;
      csum_err_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      sum_q      <= sum_d;
      tmr_q      <= tmr_d;
      len_err_q  <= len_err_d;
      csum_err_q <= csum_err_d;
      tmo_err_q  <= tmo_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  // Payload buffer carries no reset; its contents only matter in DRAIN.
  always_ff @(posedge sys_clk_i) begin
    if (wr_en) mem[idx_q[AW-1:0]] <= rx_data_i;
  end

endmodule
